// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB write-back arbiter.
//   Q_WIDTH : default ROB index width
//   XLEN    : data path width (result value and next PC)
//   SRC_EX / SRC_SLB : encodings of cdb_src and of the last_grant register
package cdb_arbiter_pkg;

  localparam int   Q_WIDTH = 4;
  localparam int   XLEN    = 32;

  localparam logic SRC_EX  = 1'b0;
  localparam logic SRC_SLB = 1'b1;

endpackage

// File: rtl/cdb_fifo.sv
// Small skid FIFO placed in front of the CDB arbiter, one per result producer.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   en             : global enable; low freezes every register
//   flush          : empties the FIFO (takes effect only while en is high)
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head_data      : current head entry, valid whenever empty is low
//   count/full/empty : occupancy status
module cdb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // The head is read combinationally so an entry written at the end of one
  // cycle can be granted in the very next cycle.
  assign head_data = mem[rd_ptr_q];

  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Write-back arbiter sharing the common data bus between the ALU execute
// stage and the store/load buffer. Each producer feeds a skid FIFO; one head
// per cycle is granted round-robin and registered onto the CDB.
//   clk_in, rst_in, rdy_in, flush : clock, async reset, global enable, mispredict flush
//   ex_*   : ALU result handshake (rob_pos, value, resolved next PC)
//   slb_*  : SLB result handshake (rob_pos, load value)
//   cdb_*  : registered CDB beat (valid pulse, source, rob_pos, value, next PC)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int Q_WIDTH = cdb_arbiter_pkg::Q_WIDTH,
  parameter int DEPTH   = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [Q_WIDTH-1:0] ex_rob_pos,
  input  logic [XLEN-1:0]    ex_value,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               slb_valid,
  output logic               slb_ready,
  input  logic [Q_WIDTH-1:0] slb_rob_pos,
  input  logic [XLEN-1:0]    slb_value,
  output logic               cdb_valid,
  output logic               cdb_src,
  output logic [Q_WIDTH-1:0] cdb_rob_pos,
  output logic [XLEN-1:0]    cdb_value,
  output logic [XLEN-1:0]    cdb_pc
);

  localparam int EX_W  = Q_WIDTH + 2 * XLEN;
  localparam int SLB_W = Q_WIDTH + XLEN;

  logic [EX_W-1:0]         ex_head;
  logic [SLB_W-1:0]        slb_head;
  logic [$clog2(DEPTH):0]  ex_count, slb_count;
  logic                    ex_full, ex_empty, slb_full, slb_empty;
  logic                    ex_push, slb_push, ex_pop, slb_pop;

  logic                    grant_valid;
  logic                    grant_src;

  logic                    last_grant_q, last_grant_d;
  logic                    cdb_valid_q, cdb_valid_d;
  logic                    cdb_src_q, cdb_src_d;
  logic [Q_WIDTH-1:0]      cdb_rob_pos_q, cdb_rob_pos_d;
  logic [XLEN-1:0]         cdb_value_q, cdb_value_d;
  logic [XLEN-1:0]         cdb_pc_q, cdb_pc_d;

  // No enqueue into a full FIFO even if its head leaves this cycle: ready
  // must not depend on the grant.
  assign ex_ready  = !ex_full && rdy_in && !flush;
  assign slb_ready = !slb_full && rdy_in && !flush;
  assign ex_push   = ex_valid && ex_ready;
  assign slb_push  = slb_valid && slb_ready;

  cdb_fifo #(.WIDTH(EX_W), .DEPTH(DEPTH)) u_ex_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .flush     (flush),
    .push      (ex_push),
    .push_data ({ex_rob_pos, ex_value, ex_pc}),
    .pop       (ex_pop),
    .head_data (ex_head),
    .count     (ex_count),
    .full      (ex_full),
    .empty     (ex_empty)
  );

  cdb_fifo #(.WIDTH(SLB_W), .DEPTH(DEPTH)) u_slb_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .flush     (flush),
    .push      (slb_push),
    .push_data ({slb_rob_pos, slb_value}),
    .pop       (slb_pop),
    .head_data (slb_head),
    .count     (slb_count),
    .full      (slb_full),
    .empty     (slb_empty)
  );

  // Round-robin: under contention the source that did not win last time goes.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_EX;
    if (!ex_empty && !slb_empty) begin
      grant_valid = 1'b1;
      grant_src   = ~last_grant_q;
    end else if (!ex_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_EX;
    end else if (!slb_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_SLB;
    end
  end

  // The FIFOs themselves ignore pops while disabled or flushing.
  assign ex_pop  = grant_valid && (grant_src == SRC_EX);
  assign slb_pop = grant_valid && (grant_src == SRC_SLB);

  always_comb begin
    last_grant_d  = last_grant_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_src_d     = cdb_src_q;
    cdb_rob_pos_d = cdb_rob_pos_q;
    cdb_value_d   = cdb_value_q;
    cdb_pc_d      = cdb_pc_q;
    if (rdy_in) begin
      if (flush) begin
        cdb_valid_d  = 1'b0;
        last_grant_d = SRC_SLB;
      end else if (grant_valid) begin
        cdb_valid_d  = 1'b1;
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
        if (grant_src == SRC_EX) begin
          {cdb_rob_pos_d, cdb_value_d, cdb_pc_d} = ex_head;
        end else begin
          {cdb_rob_pos_d, cdb_value_d} = slb_head;
          cdb_pc_d = '0;
        end
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // last_grant resets to SLB so the ALU wins the first tie.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant_q  <= SRC_SLB;
      cdb_valid_q   <= 1'b0;
      cdb_src_q     <= 1'b0;
      cdb_rob_pos_q <= '0;
      cdb_value_q   <= '0;
      cdb_pc_q      <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_src_q     <= cdb_src_d;
      cdb_rob_pos_q <= cdb_rob_pos_d;
      cdb_value_q   <= cdb_value_d;
      cdb_pc_q      <= cdb_pc_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_src     = cdb_src_q;
  assign cdb_rob_pos = cdb_rob_pos_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_pc      = cdb_pc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

  localparam int QW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic [QW-1:0] ex_rob_pos;
  logic [31:0]   ex_value;
  logic [31:0]   ex_pc;
  logic          slb_valid;
  logic          slb_ready;
  logic [QW-1:0] slb_rob_pos;
  logic [31:0]   slb_value;
  logic          cdb_valid;
  logic          cdb_src;
  logic [QW-1:0] cdb_rob_pos;
  logic [31:0]   cdb_value;
  logic [31:0]   cdb_pc;

  int n_checks = 0;
  int n_pass   = 0;

  cdb_arbiter #(.Q_WIDTH(QW), .DEPTH(2)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rob_pos  (ex_rob_pos),
    .ex_value    (ex_value),
    .ex_pc       (ex_pc),
    .slb_valid   (slb_valid),
    .slb_ready   (slb_ready),
    .slb_rob_pos (slb_rob_pos),
    .slb_value   (slb_value),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .cdb_rob_pos (cdb_rob_pos),
    .cdb_value   (cdb_value),
    .cdb_pc      (cdb_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_beat(input string tag, input logic src, input logic [QW-1:0] pos,
                          input logic [31:0] val, input logic [31:0] pc);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, ".src"},   64'(cdb_src), 64'(src));
    chk({tag, ".pos"},   64'(cdb_rob_pos), 64'(pos));
    chk({tag, ".value"}, 64'(cdb_value), 64'(val));
    chk({tag, ".pc"},    64'(cdb_pc), 64'(pc));
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0; ex_rob_pos  = '0; ex_value  = '0; ex_pc = '0;
    slb_valid = 1'b0; slb_rob_pos = '0; slb_value = '0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    tick();
  endtask

  task automatic drive_ex(input logic [QW-1:0] pos, input logic [31:0] val, input logic [31:0] pc);
    ex_valid = 1'b1; ex_rob_pos = pos; ex_value = val; ex_pc = pc;
  endtask

  task automatic drive_slb(input logic [QW-1:0] pos, input logic [31:0] val);
    slb_valid = 1'b1; slb_rob_pos = pos; slb_value = val;
  endtask

  int  ei, si, k, gaps, idle_hits;
  logic ex_acc, slb_acc, saw_ex_block, saw_slb_block;
  logic        exp_src;
  logic [QW-1:0] exp_pos;

  initial begin
    // ---------------- reset state ----------------
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    #2;
    chk("rst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst.cdb_src",   64'(cdb_src), 64'd0);
    chk("rst.cdb_pos",   64'(cdb_rob_pos), 64'd0);
    chk("rst.cdb_value", 64'(cdb_value), 64'd0);
    chk("rst.cdb_pc",    64'(cdb_pc), 64'd0);
    chk("rst.ex_ready",  64'(ex_ready), 64'd1);
    chk("rst.slb_ready", 64'(slb_ready), 64'd1);
    @(negedge clk_in);
    rst_in = 1'b0;
    tick();

    // ---------------- single ALU push ----------------
    tick(); tick();
    drive_ex(4'd3, 32'hDEADBEEF, 32'h100);
    tick();
    idle_inputs();
    chk("single.t+1_valid", 64'(cdb_valid), 64'd0);
    tick();
    chk_beat("single.t+2", 1'b0, 4'd3, 32'hDEADBEEF, 32'h100);
    tick();
    chk("single.t+3_valid", 64'(cdb_valid), 64'd0);

    // ---------------- simultaneous pairs after reset ----------------
    do_reset();
    drive_ex(4'd1, 32'hA1, 32'hB1);
    drive_slb(4'd2, 32'hC2);
    tick();
    idle_inputs();
    chk("pair1.gap", 64'(cdb_valid), 64'd0);
    tick();
    chk_beat("pair1.first", 1'b0, 4'd1, 32'hA1, 32'hB1);
    tick();
    chk_beat("pair1.second", 1'b1, 4'd2, 32'hC2, 32'h0);
    tick();
    chk("pair1.drained", 64'(cdb_valid), 64'd0);
    drive_ex(4'd4, 32'hA4, 32'hB4);
    drive_slb(4'd5, 32'hC5);
    tick();
    idle_inputs();
    tick();
    chk_beat("pair2.first", 1'b0, 4'd4, 32'hA4, 32'hB4);
    tick();
    chk_beat("pair2.second", 1'b1, 4'd5, 32'hC5, 32'h0);
    tick();
    chk("pair2.drained", 64'(cdb_valid), 64'd0);

    // ---------------- saturation: both push every cycle ----------------
    // From reset the beats must be EX0,SLB0,EX1,SLB1,...,EX9,SLB9 back to back.
    do_reset();
    ei = 0; si = 0; k = 0; gaps = 0;
    saw_ex_block = 1'b0; saw_slb_block = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ex_valid    = (ei < 10);
      ex_rob_pos  = QW'(ei);
      ex_value    = 32'h1000 + 32'(ei);
      ex_pc       = 32'h2000 + 32'(ei);
      slb_valid   = (si < 10);
      slb_rob_pos = QW'(si);
      slb_value   = 32'h3000 + 32'(si);
      #1;
      ex_acc  = ex_valid && ex_ready;
      slb_acc = slb_valid && slb_ready;
      if (ex_valid && !ex_ready)   saw_ex_block  = 1'b1;
      if (slb_valid && !slb_ready) saw_slb_block = 1'b1;
      tick();
      if (ex_acc)  ei++;
      if (slb_acc) si++;
      if (cdb_valid) begin
        exp_src = k[0];
        exp_pos = QW'(k / 2);
        if (exp_src == 1'b0)
          chk_beat($sformatf("sat.beat%0d", k), 1'b0, exp_pos, 32'h1000 + 32'(exp_pos), 32'h2000 + 32'(exp_pos));
        else
          chk_beat($sformatf("sat.beat%0d", k), 1'b1, exp_pos, 32'h3000 + 32'(exp_pos), 32'h0);
        k++;
      end else if (k > 0 && k < 20) begin
        gaps++;
      end
    end
    idle_inputs();
    chk("sat.beats", 64'(k), 64'd20);
    chk("sat.gaps", 64'(gaps), 64'd0);
    chk("sat.ex_ready_dropped", 64'(saw_ex_block), 64'd1);
    chk("sat.slb_ready_dropped", 64'(saw_slb_block), 64'd1);

    // ---------------- flush ----------------
    do_reset();
    drive_ex(4'd7, 32'h70, 32'h700);
    drive_slb(4'd12, 32'hC0);
    tick();
    drive_ex(4'd8, 32'h80, 32'h800);
    drive_slb(4'd13, 32'hD0);
    tick();
    chk_beat("flush.pre_ex7", 1'b0, 4'd7, 32'h70, 32'h700);
    slb_valid = 1'b0;
    drive_ex(4'd9, 32'h90, 32'h900);
    tick();
    chk_beat("flush.pre_slb12", 1'b1, 4'd12, 32'hC0, 32'h0);
    // ALU 8,9 and SLB 13 are buffered; flush together with a new ALU push.
    drive_ex(4'd10, 32'hA0, 32'hA00);
    flush = 1'b1;
    #1;
    chk("flush.ex_ready", 64'(ex_ready), 64'd0);
    chk("flush.slb_ready", 64'(slb_ready), 64'd0);
    tick();
    idle_inputs();
    chk("flush.next_valid", 64'(cdb_valid), 64'd0);
    idle_hits = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cdb_valid) idle_hits++;
    end
    chk("flush.no_stale_beats", 64'(idle_hits), 64'd0);
    drive_ex(4'd6, 32'h66, 32'h660);
    tick();
    idle_inputs();
    chk("flush.fresh_gap", 64'(cdb_valid), 64'd0);
    tick();
    chk_beat("flush.fresh", 1'b0, 4'd6, 32'h66, 32'h660);

    // ---------------- rdy_in stall ----------------
    do_reset();
    drive_ex(4'd1, 32'h11, 32'h110);
    drive_slb(4'd1, 32'h21);
    tick();
    drive_ex(4'd2, 32'h12, 32'h120);
    drive_slb(4'd2, 32'h22);
    tick();
    chk_beat("stall.pre_ex1", 1'b0, 4'd1, 32'h11, 32'h110);
    idle_inputs();
    rdy_in = 1'b0;
    #1;
    chk("stall.ex_ready_low", 64'(ex_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_beat($sformatf("stall.hold%0d", c), 1'b0, 4'd1, 32'h11, 32'h110);
    end
    rdy_in = 1'b1;
    #1;
    // ALU FIFO still holds one entry, SLB FIFO two.
    chk("stall.resume_ex_ready", 64'(ex_ready), 64'd1);
    chk("stall.resume_slb_ready", 64'(slb_ready), 64'd0);
    tick();
    chk_beat("stall.resume_slb1", 1'b1, 4'd1, 32'h21, 32'h0);
    tick();
    chk_beat("stall.resume_ex2", 1'b0, 4'd2, 32'h12, 32'h120);
    tick();
    chk_beat("stall.resume_slb2", 1'b1, 4'd2, 32'h22, 32'h0);
    tick();
    chk("stall.drained", 64'(cdb_valid), 64'd0);

    // ---------------- asynchronous reset mid-beat ----------------
    do_reset();
    drive_ex(4'd3, 32'h33, 32'h330);
    drive_slb(4'd4, 32'h44);
    tick();
    idle_inputs();
    tick();
    chk_beat("arst.pre", 1'b0, 4'd3, 32'h33, 32'h330);
    #3;
    rst_in = 1'b1;
    #1;
    chk("arst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("arst.cdb_src",   64'(cdb_src), 64'd0);
    chk("arst.cdb_pos",   64'(cdb_rob_pos), 64'd0);
    chk("arst.cdb_value", 64'(cdb_value), 64'd0);
    chk("arst.cdb_pc",    64'(cdb_pc), 64'd0);
    rst_in = 1'b0;
    #1;
    chk("arst.ex_ready",  64'(ex_ready), 64'd1);
    chk("arst.slb_ready", 64'(slb_ready), 64'd1);
    tick();
    chk("arst.slb_discarded", 64'(cdb_valid), 64'd0);
    tick();
    chk("arst.still_idle", 64'(cdb_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
